pc_stacked: RTL and testbench
=============================

Name: pc_stacked

Overview:
- Parametrised successor to the CR16 program counter.
- Clocked, clock-enabled PC with an encoded next-address mode: increment, absolute jump, jump+1, signed displacement, call, return, hold.
- Adds a hardware return-address stack (RAS) for call/return, with empty/full status and a sticky fault flag.
- Sits between the CR16 control FSM and instruction-memory address port.

Parameters:
- P_ADDRESS_WIDTH, 16, width of I_ADDRESS / O_ADDRESS and of each stack entry.
- P_STACK_DEPTH, 8, number of RAS entries; power of two, >= 2.
- P_RESET_ADDRESS, 0, value loaded into O_ADDRESS on reset.

Ports:
- I_CLK  input  1  clock, rising edge.
- I_NRESET  input  1  asynchronous active-low reset.
- I_ENABLE  input  1  clock enable; when low, all state holds.
- I_MODE  input  3  next-address mode (pc_mode_t).
- I_ADDRESS  input  P_ADDRESS_WIDTH  jump target or signed displacement.
- I_FAULT_CLEAR  input  1  clears O_FAULT.
- O_ADDRESS  output  P_ADDRESS_WIDTH  current PC.
- O_STACK_EMPTY  output  1  RAS holds 0 entries.
- O_STACK_FULL  output  1  RAS holds P_STACK_DEPTH entries.
- O_FAULT  output  1  sticky RAS overflow/underflow indicator.

Behaviour:
- Reset (async, any time, including mid-operation):
  - O_ADDRESS=P_RESET_ADDRESS; RAS count=0; O_STACK_EMPTY=1; O_STACK_FULL=0; O_FAULT=0.
  - RAS contents are don't-care.
- Update rule: all updates occur on the rising edge of I_CLK with I_ENABLE=1. Results are visible one cycle later; there is no combinational path from inputs to O_ADDRESS.
- Modes (PC = O_ADDRESS; all arithmetic is modulo 2^P_ADDRESS_WIDTH and wraps silently):
  - MODE_INC (0): PC <= PC+1.
  - MODE_JUMP (1): PC <= I_ADDRESS.
  - MODE_JUMP_INC (2): PC <= I_ADDRESS+1.
  - MODE_DISP (3): PC <= PC + $signed(I_ADDRESS).
  - MODE_CALL (4): push PC+1; then PC <= I_ADDRESS.
  - MODE_RET (5): pop the top entry into PC.
  - MODE_HOLD (6): PC unchanged.
  - 7 (reserved): treated as MODE_HOLD; sets O_FAULT.
- RAS organisation:
  - Circular buffer: top pointer of log2(P_STACK_DEPTH) bits, plus a count of log2(P_STACK_DEPTH)+1 bits.
  - O_STACK_EMPTY = (count==0); O_STACK_FULL = (count==P_STACK_DEPTH).
- CALL when full: the push overwrites the oldest entry; count stays at P_STACK_DEPTH; O_FAULT <= 1; the jump still occurs.
- RET when empty: PC <= PC+1; stack unchanged; O_FAULT <= 1.
- Consecutive CALL/RET pairs return correctly to depth P_STACK_DEPTH.
- RET immediately after CALL returns the address pushed by that CALL.
- O_FAULT priority: a set in the same cycle as I_FAULT_CLEAR wins (O_FAULT stays 1). I_FAULT_CLEAR acts independently of I_ENABLE.

Optional Feature:
- Macro: PC_STACKED_TRAP_EN.
- Defined:
  - Adds ports I_TRAP (input 1) and O_IN_TRAP (output 1), and parameter P_TRAP_VECTOR (default 16'h0010).
  - I_TRAP=1 with I_ENABLE=1 overrides I_MODE: behaves as CALL to P_TRAP_VECTOR, except that the pushed address is PC (re-execute), not PC+1. O_IN_TRAP <= 1.
  - The next MODE_RET clears O_IN_TRAP.
  - I_TRAP while O_IN_TRAP=1 is ignored.
  - Reset clears O_IN_TRAP.
- Undefined: ports and parameter absent; behaviour exactly as above.

Decomposition:
- cr16_pkg holds:
  - typedef enum logic [2:0] pc_mode_t (MODE_INC..MODE_HOLD).
  - Constant PC_MODE_WIDTH=3.
- Sub-module pc_return_stack (circular LIFO):
  - Parameters P_WIDTH and P_DEPTH.
  - Ports I_CLK, I_NRESET, I_PUSH, I_POP, I_DATA, O_TOP, O_EMPTY, O_FULL, O_OVERFLOW, O_UNDERFLOW.
- pc_stacked owns next-address mux, fault logic and trap logic.

Test Plan:
- Reset and increment: reset with P_RESET_ADDRESS=0; 5 cycles MODE_INC -> O_ADDRESS 1,2,3,4,5; assert I_NRESET=0 mid-cycle -> O_ADDRESS=0 immediately.
- Jump and displacement: at PC=0x0020, DISP 16'hFFFC -> 0x001C; JUMP 0x1234 -> 0x1234; JUMP_INC 0xFFFF -> 0x0000; I_ENABLE=0 with MODE_JUMP -> PC holds.
- Nested calls: from 0x0100, CALL 0x0200, CALL 0x0300, RET, RET -> 0x0200, 0x0300, 0x0201, 0x0101; O_STACK_EMPTY=1 at end.
- Overflow wrap: P_STACK_DEPTH=8; 9 CALLs from PCs 0x10..0x18 -> O_STACK_FULL=1, O_FAULT=1; 8 RETs return 0x19..0x12 in order; a 9th RET -> PC+1 and O_FAULT stays 1.
- Fault clear: O_FAULT=1, pulse I_FAULT_CLEAR -> 0; RET-on-empty in the same cycle as I_FAULT_CLEAR -> O_FAULT=1; I_MODE=7 -> PC holds, O_FAULT=1.
- Trap (PC_STACKED_TRAP_EN): at PC=0x0040, I_TRAP -> PC=0x0010, O_IN_TRAP=1; second I_TRAP ignored; RET -> PC=0x0040, O_IN_TRAP=0.

Source files
------------

// File: rtl/cr16_pkg.sv
// Shared CR16 program-counter definitions: next-address mode encoding.
package cr16_pkg;

  localparam int PC_MODE_WIDTH = 3;

  // Encoded next-address selection driven by the control FSM.
  // Code 7 is reserved: the PC holds and the fault flag is raised.
  typedef enum logic [PC_MODE_WIDTH-1:0] {
    MODE_INC      = 3'd0,
    MODE_JUMP     = 3'd1,
    MODE_JUMP_INC = 3'd2,
    MODE_DISP     = 3'd3,
    MODE_CALL     = 3'd4,
    MODE_RET      = 3'd5,
    MODE_HOLD     = 3'd6
  } pc_mode_t;

endpackage

// File: rtl/pc_return_stack.sv
// Circular return-address LIFO. A push when full overwrites the oldest entry
// (the slot just past the top wraps onto it); a pop when empty is ignored.
// O_OVERFLOW / O_UNDERFLOW flag those two cases combinationally for this cycle.
module pc_return_stack #(
  parameter int P_WIDTH = 16,
  parameter int P_DEPTH = 8
) (
  input  logic               I_CLK,
  input  logic               I_NRESET,
  input  logic               I_PUSH,
  input  logic               I_POP,
  input  logic [P_WIDTH-1:0] I_DATA,
  output logic [P_WIDTH-1:0] O_TOP,
  output logic               O_EMPTY,
  output logic               O_FULL,
  output logic               O_OVERFLOW,
  output logic               O_UNDERFLOW
);

  localparam int PTR_W = $clog2(P_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [P_WIDTH-1:0] mem [P_DEPTH];
  logic [PTR_W-1:0]   top_q;
  logic [PTR_W-1:0]   top_nxt;
  logic [PTR_W-1:0]   top_prv;
  logic [CNT_W-1:0]   count_q;

  assign top_nxt     = top_q + PTR_W'(1);
  assign top_prv     = top_q - PTR_W'(1);
  assign O_EMPTY     = (count_q == '0);
  assign O_FULL      = (count_q == CNT_W'(P_DEPTH));
  assign O_OVERFLOW  = I_PUSH & O_FULL;
  assign O_UNDERFLOW = I_POP & ~I_PUSH & O_EMPTY;
  assign O_TOP       = mem[top_q];

  // Top pointer and occupancy; count saturates at P_DEPTH on overwrite.
  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      top_q   <= '0;
      count_q <= '0;
    end else if (I_PUSH) begin
      top_q <= top_nxt;
      if (!O_FULL) count_q <= count_q + CNT_W'(1);
    end else if (I_POP && !O_EMPTY) begin
      top_q   <= top_prv;
      count_q <= count_q - CNT_W'(1);
    end
  end

  // Entry storage; contents are don't-care after reset.
  always_ff @(posedge I_CLK) begin
    if (I_PUSH) mem[top_nxt] <= I_DATA;
  end

endmodule

// File: rtl/pc_stacked.sv
// CR16 program counter with hardware return-address stack.
// Optional trap entry enabled by defining PC_STACKED_TRAP_EN.
module pc_stacked
  import cr16_pkg::*;
#(
  parameter int                       P_ADDRESS_WIDTH = 16,
  parameter int                       P_STACK_DEPTH   = 8,
  parameter logic [P_ADDRESS_WIDTH-1:0] P_RESET_ADDRESS = '0
`ifdef PC_STACKED_TRAP_EN
  ,
  parameter logic [P_ADDRESS_WIDTH-1:0] P_TRAP_VECTOR = 16'h0010
`endif
) (
  input  logic                       I_CLK,
  input  logic                       I_NRESET,
  input  logic                       I_ENABLE,
  input  logic [PC_MODE_WIDTH-1:0]   I_MODE,
  input  logic [P_ADDRESS_WIDTH-1:0] I_ADDRESS,
  input  logic                       I_FAULT_CLEAR,
`ifdef PC_STACKED_TRAP_EN
  input  logic                       I_TRAP,
  output logic                       O_IN_TRAP,
`endif
  output logic [P_ADDRESS_WIDTH-1:0] O_ADDRESS,
  output logic                       O_STACK_EMPTY,
  output logic                       O_STACK_FULL,
  output logic                       O_FAULT
);

  localparam logic [P_ADDRESS_WIDTH-1:0] ONE = P_ADDRESS_WIDTH'(1);

  logic [P_ADDRESS_WIDTH-1:0] pc_q, pc_d, pc_inc, push_data, stack_top;
  logic push, pop, overflow, underflow, mode_fault, fault_q, fault_set;
  logic trap_take;

`ifdef PC_STACKED_TRAP_EN
  logic in_trap_q;
  assign trap_take = I_TRAP & ~in_trap_q;
  assign O_IN_TRAP = in_trap_q;
`else
  assign trap_take = 1'b0;
`endif

  assign pc_inc    = pc_q + ONE;
  assign O_ADDRESS = pc_q;
  assign O_FAULT   = fault_q;
  assign fault_set = overflow | underflow | mode_fault;

  // Next-address mux and stack requests; nothing happens unless enabled.
  always_comb begin
    pc_d       = pc_q;
    push       = 1'b0;
    pop        = 1'b0;
    mode_fault = 1'b0;
    push_data  = pc_inc;
    if (I_ENABLE) begin
      if (trap_take) begin
        push      = 1'b1;
        push_data = pc_q;
`ifdef PC_STACKED_TRAP_EN
        pc_d      = P_TRAP_VECTOR;
`endif
      end else begin
        case (I_MODE)
          MODE_INC:      pc_d = pc_inc;
          MODE_JUMP:     pc_d = I_ADDRESS;
          MODE_JUMP_INC: pc_d = I_ADDRESS + ONE;
          MODE_DISP:     pc_d = pc_q + I_ADDRESS;
          MODE_CALL: begin
            push = 1'b1;
            pc_d = I_ADDRESS;
          end
          MODE_RET: begin
            pop  = 1'b1;
            pc_d = O_STACK_EMPTY ? pc_inc : stack_top;
          end
          MODE_HOLD:     pc_d = pc_q;
          default:       mode_fault = 1'b1;
        endcase
      end
    end
  end

  // PC register.
  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) pc_q <= P_RESET_ADDRESS;
    else           pc_q <= pc_d;
  end

  // Sticky fault: a new fault in the same cycle as a clear wins.
  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET)          fault_q <= 1'b0;
    else if (fault_set)     fault_q <= 1'b1;
    else if (I_FAULT_CLEAR) fault_q <= 1'b0;
  end

`ifdef PC_STACKED_TRAP_EN
  // Trap-in-progress flag, cleared by the next enabled return.
  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET)                               in_trap_q <= 1'b0;
    else if (I_ENABLE && trap_take)              in_trap_q <= 1'b1;
    else if (I_ENABLE && (I_MODE == MODE_RET))   in_trap_q <= 1'b0;
  end
`endif

  pc_return_stack #(
    .P_WIDTH (P_ADDRESS_WIDTH),
    .P_DEPTH (P_STACK_DEPTH)
  ) u_ras (
    .I_CLK       (I_CLK),
    .I_NRESET    (I_NRESET),
    .I_PUSH      (push),
    .I_POP       (pop),
    .I_DATA      (push_data),
    .O_TOP       (stack_top),
    .O_EMPTY     (O_STACK_EMPTY),
    .O_FULL      (O_STACK_FULL),
    .O_OVERFLOW  (overflow),
    .O_UNDERFLOW (underflow)
  );

endmodule

// File: tb/tb_pc_stacked.sv
// Self-checking bench for pc_stacked (trap tests included when
// PC_STACKED_TRAP_EN is defined).
module tb_pc_stacked;

  localparam int AW    = 16;
  localparam int DEPTH = 8;
  localparam logic [AW-1:0] TRAP_VEC = 16'h0010;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic [2:0]    mode = 3'd6;
  logic [AW-1:0] addr = '0;
  logic          fclr = 1'b0;
  logic          trap = 1'b0;
  logic          in_trap;
  logic [AW-1:0] o_address;
  logic          o_empty, o_full, o_fault;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: PC, return stack as a bounded queue, flags.
  logic [AW-1:0] m_pc;
  logic [AW-1:0] exp_q[$];
  logic          m_fault;
  logic          m_trap;

  pc_stacked #(
    .P_ADDRESS_WIDTH (AW),
    .P_STACK_DEPTH   (DEPTH),
    .P_RESET_ADDRESS (16'h0000)
`ifdef PC_STACKED_TRAP_EN
    , .P_TRAP_VECTOR (TRAP_VEC)
`endif
  ) dut (
    .I_CLK         (clk),
    .I_NRESET      (rst_n),
    .I_ENABLE      (en),
    .I_MODE        (mode),
    .I_ADDRESS     (addr),
    .I_FAULT_CLEAR (fclr),
`ifdef PC_STACKED_TRAP_EN
    .I_TRAP        (trap),
    .O_IN_TRAP     (in_trap),
`endif
    .O_ADDRESS     (o_address),
    .O_STACK_EMPTY (o_empty),
    .O_STACK_FULL  (o_full),
    .O_FAULT       (o_fault)
  );

`ifndef PC_STACKED_TRAP_EN
  assign in_trap = 1'b0;
`endif

  // Clock
  always #5 clk = ~clk;

  task automatic model_reset();
    m_pc = '0;
    exp_q.delete();
    m_fault = 1'b0;
    m_trap = 1'b0;
  endtask

  // Model one enabled/disabled clock edge from the architectural rules.
  task automatic model_step(input logic e, input logic [2:0] md,
                            input logic [AW-1:0] a, input logic fc, input logic tr);
    logic set;
    set = 1'b0;
    if (e) begin
`ifdef PC_STACKED_TRAP_EN
      if (tr && !m_trap) begin
        if (exp_q.size() == DEPTH) begin void'(exp_q.pop_front()); set = 1'b1; end
        exp_q.push_back(m_pc);
        m_pc = TRAP_VEC;
        m_trap = 1'b1;
      end else
`endif
      begin
        case (md)
          3'd0: m_pc = m_pc + 16'd1;
          3'd1: m_pc = a;
          3'd2: m_pc = a + 16'd1;
          3'd3: m_pc = AW'(int'($signed(m_pc)) + int'($signed(a)));
          3'd4: begin
            if (exp_q.size() == DEPTH) begin void'(exp_q.pop_front()); set = 1'b1; end
            exp_q.push_back(m_pc + 16'd1);
            m_pc = a;
          end
          3'd5: begin
            if (exp_q.size() == 0) begin m_pc = m_pc + 16'd1; set = 1'b1; end
            else m_pc = exp_q.pop_back();
            m_trap = 1'b0;
          end
          3'd6: ;
          default: set = 1'b1;
        endcase
      end
    end
    if (set) m_fault = 1'b1;
    else if (fc) m_fault = 1'b0;
  endtask

  // Driver: inputs change on negedge, model advances on posedge, sample #1 later.
  task automatic apply(input logic e, input logic [2:0] md, input logic [AW-1:0] a,
                       input logic fc, input logic tr);
    @(negedge clk);
    en = e; mode = md; addr = a; fclr = fc; trap = tr;
    @(posedge clk);
    model_step(e, md, a, fc, tr);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; en = 1'b0; fclr = 1'b0; trap = 1'b0; mode = 3'd6;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (o_address !== 16'h0000) begin n_bad++; $display("FAIL reset_pc got %h want 0000", o_address); end
    n_cmp++; if (o_empty !== 1'b1) begin n_bad++; $display("FAIL reset_empty got %b want 1", o_empty); end
    n_cmp++; if (o_full !== 1'b0) begin n_bad++; $display("FAIL reset_full got %b want 0", o_full); end
    n_cmp++; if (o_fault !== 1'b0) begin n_bad++; $display("FAIL reset_fault got %b want 0", o_fault); end
    n_cmp++; if (in_trap !== 1'b0) begin n_bad++; $display("FAIL reset_in_trap got %b want 0", in_trap); end
  endtask

  task automatic test_increment();
    for (int i = 1; i <= 5; i++) begin
      apply(1'b1, 3'd0, '0, 1'b0, 1'b0);
      n_cmp++;
      if (o_address !== AW'(i)) begin n_bad++; $display("FAIL inc_%0d got %h want %h", i, o_address, AW'(i)); end
    end
    // Asynchronous reset asserted mid-cycle takes effect immediately.
    @(posedge clk); #2; rst_n = 1'b0; #1;
    model_reset();
    n_cmp++; if (o_address !== 16'h0000) begin n_bad++; $display("FAIL async_reset got %h want 0000", o_address); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_jump_disp();
    apply(1'b1, 3'd1, 16'h0020, 1'b0, 1'b0);
    apply(1'b1, 3'd3, 16'hFFFC, 1'b0, 1'b0);
    n_cmp++; if (o_address !== 16'h001C) begin n_bad++; $display("FAIL disp_neg got %h want 001c", o_address); end
    apply(1'b1, 3'd1, 16'h1234, 1'b0, 1'b0);
    n_cmp++; if (o_address !== 16'h1234) begin n_bad++; $display("FAIL jump got %h want 1234", o_address); end
    apply(1'b1, 3'd2, 16'hFFFF, 1'b0, 1'b0);
    n_cmp++; if (o_address !== 16'h0000) begin n_bad++; $display("FAIL jump_inc_wrap got %h want 0000", o_address); end
    apply(1'b0, 3'd1, 16'h5555, 1'b0, 1'b0);
    n_cmp++; if (o_address !== 16'h0000) begin n_bad++; $display("FAIL enable_low got %h want 0000", o_address); end
  endtask

  task automatic test_nested_calls();
    logic [AW-1:0] want [4];
    logic [2:0]    md   [4];
    logic [AW-1:0] tgt  [4];
    want = '{16'h0200, 16'h0300, 16'h0201, 16'h0101};
    md   = '{3'd4, 3'd4, 3'd5, 3'd5};
    tgt  = '{16'h0200, 16'h0300, 16'h0000, 16'h0000};
    do_reset();
    apply(1'b1, 3'd1, 16'h0100, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, md[i], tgt[i], 1'b0, 1'b0);
      n_cmp++; if (o_address !== want[i]) begin n_bad++; $display("FAIL nested_%0d got %h want %h", i, o_address, want[i]); end
    end
    n_cmp++; if (o_empty !== 1'b1) begin n_bad++; $display("FAIL nested_empty got %b want 1", o_empty); end
    n_cmp++; if (o_fault !== 1'b0) begin n_bad++; $display("FAIL nested_fault got %b want 0", o_fault); end
  endtask

  task automatic test_overflow();
    do_reset();
    apply(1'b1, 3'd1, 16'h0010, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) apply(1'b1, 3'd4, AW'(16'h0011 + i), 1'b0, 1'b0);
    n_cmp++; if (o_full !== 1'b1) begin n_bad++; $display("FAIL ovf_full got %b want 1", o_full); end
    n_cmp++; if (o_fault !== 1'b1) begin n_bad++; $display("FAIL ovf_fault got %b want 1", o_fault); end
    for (int i = 0; i < 8; i++) begin
      apply(1'b1, 3'd5, '0, 1'b0, 1'b0);
      n_cmp++;
      if (o_address !== AW'(16'h0019 - i)) begin n_bad++; $display("FAIL ovf_ret_%0d got %h want %h", i, o_address, AW'(16'h0019 - i)); end
    end
    n_cmp++; if (o_empty !== 1'b1) begin n_bad++; $display("FAIL ovf_empty got %b want 1", o_empty); end
    apply(1'b1, 3'd5, '0, 1'b0, 1'b0);
    n_cmp++; if (o_address !== 16'h0013) begin n_bad++; $display("FAIL unf_pc got %h want 0013", o_address); end
    n_cmp++; if (o_fault !== 1'b1) begin n_bad++; $display("FAIL unf_fault got %b want 1", o_fault); end
  endtask

  task automatic test_fault_clear();
    apply(1'b1, 3'd6, '0, 1'b1, 1'b0);
    n_cmp++; if (o_fault !== 1'b0) begin n_bad++; $display("FAIL fclr got %b want 0", o_fault); end
    apply(1'b1, 3'd5, '0, 1'b1, 1'b0);
    n_cmp++; if (o_fault !== 1'b1) begin n_bad++; $display("FAIL set_beats_clr got %b want 1", o_fault); end
    n_cmp++; if (o_address !== 16'h0014) begin n_bad++; $display("FAIL unf_pc2 got %h want 0014", o_address); end
    apply(1'b0, 3'd0, '0, 1'b1, 1'b0);
    n_cmp++; if (o_fault !== 1'b0) begin n_bad++; $display("FAIL fclr_no_en got %b want 0", o_fault); end
    apply(1'b1, 3'd7, 16'hAAAA, 1'b0, 1'b0);
    n_cmp++; if (o_address !== 16'h0014) begin n_bad++; $display("FAIL rsvd_hold got %h want 0014", o_address); end
    n_cmp++; if (o_fault !== 1'b1) begin n_bad++; $display("FAIL rsvd_fault got %b want 1", o_fault); end
  endtask

`ifdef PC_STACKED_TRAP_EN
  task automatic test_trap();
    do_reset();
    apply(1'b1, 3'd1, 16'h0040, 1'b0, 1'b0);
    apply(1'b1, 3'd0, '0, 1'b0, 1'b1);
    n_cmp++; if (o_address !== 16'h0010) begin n_bad++; $display("FAIL trap_pc got %h want 0010", o_address); end
    n_cmp++; if (in_trap !== 1'b1) begin n_bad++; $display("FAIL trap_flag got %b want 1", in_trap); end
    apply(1'b1, 3'd6, '0, 1'b0, 1'b1);
    n_cmp++; if (o_address !== 16'h0010) begin n_bad++; $display("FAIL trap_ignored got %h want 0010", o_address); end
    apply(1'b1, 3'd5, '0, 1'b0, 1'b0);
    n_cmp++; if (o_address !== 16'h0040) begin n_bad++; $display("FAIL trap_ret got %h want 0040", o_address); end
    n_cmp++; if (in_trap !== 1'b0) begin n_bad++; $display("FAIL trap_clear got %b want 0", in_trap); end
  endtask
`endif

  task automatic test_random();
    logic [2:0]    md;
    logic [AW-1:0] a;
    logic          e, fc, tr;
    int            r;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      r  = $urandom_range(0, 99);
      md = (r < 25) ? 3'd4 : (r < 50) ? 3'd5 : (r < 53) ? 3'd7 : 3'($urandom_range(0, 6));
      a  = AW'($urandom);
      e  = ($urandom_range(0, 9) != 0);
      fc = ($urandom_range(0, 9) == 0);
      tr = ($urandom_range(0, 19) == 0);
      apply(e, md, a, fc, tr);
      n_cmp++; if (o_address !== m_pc) begin n_bad++; $display("FAIL rand_pc[%0d] got %h want %h", i, o_address, m_pc); end
      n_cmp++; if (o_empty !== (exp_q.size() == 0)) begin n_bad++; $display("FAIL rand_empty[%0d] got %b want %b", i, o_empty, exp_q.size() == 0); end
      n_cmp++; if (o_full !== (exp_q.size() == DEPTH)) begin n_bad++; $display("FAIL rand_full[%0d] got %b want %b", i, o_full, exp_q.size() == DEPTH); end
      n_cmp++; if (o_fault !== m_fault) begin n_bad++; $display("FAIL rand_fault[%0d] got %b want %b", i, o_fault, m_fault); end
`ifdef PC_STACKED_TRAP_EN
      n_cmp++; if (in_trap !== m_trap) begin n_bad++; $display("FAIL rand_in_trap[%0d] got %b want %b", i, in_trap, m_trap); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_increment();
    test_jump_disp();
    test_nested_calls();
    test_overflow();
    test_fault_clear();
`ifdef PC_STACKED_TRAP_EN
    test_trap();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
